// File: rtl/twentyfour_downcounter.sv
// rtl/twentyfour_downcounter.sv - BCD modulo-24 down-counter with validated preset and borrow pulse
// Optional build macro ZERO_HOLD_EN: one-shot timer mode (borrow on reaching 00, then hold at 00).
module twentyfour_downcounter #(
    parameter int MAX_TENS  = 2,
    parameter int MAX_UNITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] count,
    output logic       borrow,
    output logic       load_err,
    output logic       is_zero
);

    localparam logic [3:0] TOP_TENS  = 4'(MAX_TENS);
    localparam logic [3:0] TOP_UNITS = 4'(MAX_UNITS);
    localparam logic [7:0] TOP_VALUE = {TOP_TENS, TOP_UNITS};

    logic [3:0] count_tens;
    logic [3:0] count_units;
    logic [3:0] load_tens;
    logic [3:0] load_units;
    logic       load_ok;
    logic [7:0] dec_count;
    logic       dec_borrow;

    assign count_tens  = count[7:4];
    assign count_units = count[3:0];
    assign load_tens   = load_value[7:4];
    assign load_units  = load_value[3:0];

    // The units bound only tightens once the tens digit sits at its maximum.
    assign load_ok = (load_units <= 4'd9) &&
                     (load_tens <= TOP_TENS) &&
                     ((load_tens < TOP_TENS) || (load_units <= TOP_UNITS));

    assign is_zero = (count == 8'h00);

    // Per-digit decrement; digits never exchange binary carries.
    always_comb begin
        dec_count  = count;
        dec_borrow = 1'b0;
        if (count_units != 4'd0) begin
            dec_count = {count_tens, count_units - 4'd1};
`ifdef ZERO_HOLD_EN
            dec_borrow = (count_tens == 4'd0) && (count_units == 4'd1);
`endif
        end else if (count_tens != 4'd0) begin
            dec_count = {count_tens - 4'd1, 4'd9};
        end else begin
`ifdef ZERO_HOLD_EN
            dec_count  = 8'h00;
            dec_borrow = 1'b0;
`else
            dec_count  = TOP_VALUE;
            dec_borrow = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 8'h00;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                count <= load_value;
            end
            load_err <= ~load_ok;
            borrow   <= 1'b0;
        end else if (en) begin
            count    <= dec_count;
            borrow   <= dec_borrow;
            load_err <= 1'b0;
        end else begin
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_twentyfour_downcounter.sv
// tb/tb_twentyfour_downcounter.sv - directed self-checking bench for twentyfour_downcounter
module tb_twentyfour_downcounter;

    logic       clk = 1'b0;
    logic       reset, en, load;
    logic [7:0] load_value;
    logic [7:0] count;
    logic       borrow, load_err, is_zero;

    logic       reset_b, en_b, load_b;
    logic [7:0] load_value_b;
    logic [7:0] count_b;
    logic       borrow_b, load_err_b, is_zero_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    twentyfour_downcounter u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .borrow     (borrow),
        .load_err   (load_err),
        .is_zero    (is_zero)
    );

    twentyfour_downcounter #(.MAX_TENS(5), .MAX_UNITS(9)) u_dut59 (
        .clk        (clk),
        .reset      (reset_b),
        .en         (en_b),
        .load       (load_b),
        .load_value (load_value_b),
        .count      (count_b),
        .borrow     (borrow_b),
        .load_err   (load_err_b),
        .is_zero    (is_zero_b)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic [7:0] c, input logic b,
                              input logic le, input logic z);
        check({tag, ".count"}, count, c);
        check({tag, ".borrow"}, {7'd0, borrow}, {7'd0, b});
        check({tag, ".load_err"}, {7'd0, load_err}, {7'd0, le});
        check({tag, ".is_zero"}, {7'd0, is_zero}, {7'd0, z});
    endtask

    initial begin
        logic [7:0] exp_count;
        int v;
        reset = 1'b1; en = 1'b0; load = 1'b0; load_value = 8'h00;
        reset_b = 1'b1; en_b = 1'b0; load_b = 1'b0; load_value_b = 8'h00;
        step();
        check_main("reset", 8'h00, 1'b0, 1'b0, 1'b1);
        check("reset59.count", count_b, 8'h00);
        reset = 1'b0;
        reset_b = 1'b0;

`ifndef ZERO_HOLD_EN
        // 24 decrements from reset: 23 (with borrow), 22, ..., 00
        en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            v = 23 - k;
            exp_count = {4'(v / 10), 4'(v % 10)};
            check_main($sformatf("wrap%0d", k), exp_count, (k == 0), 1'b0, (v == 0));
        end
        en = 1'b0;
`endif

        // tens-digit borrow
        load = 1'b1; load_value = 8'h10;
        step();
        check_main("load10", 8'h10, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        check_main("dec10", 8'h09, 1'b0, 1'b0, 1'b0);
        load = 1'b1; en = 1'b0; load_value = 8'h20;
        step();
        check_main("load20", 8'h20, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        check_main("dec20", 8'h19, 1'b0, 1'b0, 1'b0);
        en = 1'b0;

        // load validation
        load = 1'b1; load_value = 8'h24;
        step();
        check_main("load24", 8'h19, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        step();
        check_main("err_clear", 8'h19, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_value = 8'h1A;
        step();
        check_main("load1A", 8'h19, 1'b0, 1'b1, 1'b0);
        load_value = 8'h23;
        step();
        check_main("load23", 8'h23, 1'b0, 1'b0, 1'b0);

        // simultaneous load and en: reloads, never decrements
        load_value = 8'h15; en = 1'b1;
        step();
        check_main("load_en1", 8'h15, 1'b0, 1'b0, 1'b0);
        step();
        check_main("load_en2", 8'h15, 1'b0, 1'b0, 1'b0);

        // reset beats an invalid load
        reset = 1'b1; load_value = 8'h24;
        step();
        check_main("reset_load", 8'h00, 1'b0, 1'b0, 1'b1);
        reset = 1'b0; load = 1'b0; en = 1'b0;

`ifdef ZERO_HOLD_EN
        load = 1'b1; load_value = 8'h02;
        step();
        load = 1'b0; en = 1'b1;
        step();
        check_main("zh01", 8'h01, 1'b0, 1'b0, 1'b0);
        step();
        check_main("zh00", 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        check_main("zh00_hold", 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        check_main("zh00_hold2", 8'h00, 1'b0, 1'b0, 1'b1);
        load = 1'b1; en = 1'b0; load_value = 8'h05;
        step();
        check_main("zh_load05", 8'h05, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        check_main("zh_dec05", 8'h04, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
`else
        load = 1'b1; load_value = 8'h02;
        step();
        load = 1'b0; en = 1'b1;
        step();
        check_main("w01", 8'h01, 1'b0, 1'b0, 1'b0);
        step();
        check_main("w00", 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        check_main("w23", 8'h23, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        check_main("w_hold", 8'h23, 1'b0, 1'b0, 1'b0);
`endif

        // MAX 59 instance
        en_b = 1'b1;
        step();
`ifdef ZERO_HOLD_EN
        check("m59.count", count_b, 8'h00);
        check("m59.borrow", {7'd0, borrow_b}, 8'h00);
`else
        check("m59.count", count_b, 8'h59);
        check("m59.borrow", {7'd0, borrow_b}, 8'h01);
`endif
        en_b = 1'b0;
        load_b = 1'b1; load_value_b = 8'h45;
        step();
        check("m59.load45", count_b, 8'h45);
        load_value_b = 8'h60;
        step();
        check("m59.load60.count", count_b, 8'h45);
        check("m59.load60.err", {7'd0, load_err_b}, 8'h01);
        load_value_b = 8'h59;
        step();
        check("m59.load59.count", count_b, 8'h59);
        check("m59.load59.err", {7'd0, load_err_b}, 8'h00);
        load_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
